mod3_word_sched: RTL and testbench

MOD3_WORD_SCHED -- requirements
Module: mod3_word_sched

---
 rtl/mod3_word_sched.sv | 122 ++++++++++++
 tb/tb_mod3_word_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod3_word_sched.sv
// rtl/mod3_word_sched.sv - two-requester word scheduler computing word mod 3 by MSB-first bit-serial residue
// Optional residue output rem is built only when MOD3_REM_EN is defined.
module mod3_word_sched (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       busy,
    output logic       done,
    output logic       div3,
    output logic       gnt_id
`ifdef MOD3_REM_EN
    ,
    output logic [1:0] rem
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] sreg;
    logic [1:0] res;
    logic [2:0] cnt;
    logic       last_gnt;
    logic       cur_id;
    logic       pick;
    logic [1:0] res_nxt;

    // r' = (2r + b) mod 3, residues encoded R0=0, R1=1, R2=2
    function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
        logic [1:0] n;
        case (r)
            2'd0:    n = b ? 2'd1 : 2'd0;
            2'd1:    n = b ? 2'd0 : 2'd2;
            2'd2:    n = b ? 2'd2 : 2'd1;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

    // Round-robin: a lone requester wins; on contention the one not granted last wins
    always_comb begin
        pick    = (req0 && req1) ? ~last_gnt : req1;
        res_nxt = mod3_step(res, sreg[7]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sreg     <= 8'd0;
            res      <= 2'd0;
            cnt      <= 3'd0;
            last_gnt <= 1'b1;
            cur_id   <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div3     <= 1'b0;
            gnt_id   <= 1'b0;
`ifdef MOD3_REM_EN
            rem      <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    done <= 1'b0;
                    if (req0 || req1) begin
                        sreg     <= pick ? data1 : data0;
                        res      <= 2'd0;
                        cnt      <= 3'd0;
                        cur_id   <= pick;
                        last_gnt <= pick;
                        ack0     <= ~pick;
                        ack1     <= pick;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    res  <= res_nxt;
                    sreg <= {sreg[6:0], 1'b0};
                    cnt  <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        div3   <= (res_nxt == 2'd0);
                        gnt_id <= cur_id;
`ifdef MOD3_REM_EN
                        rem    <= res_nxt;
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod3_word_sched.sv
// tb/tb_mod3_word_sched.sv - directed and randomized bench for mod3_word_sched against a timeline/arithmetic model
module tb_mod3_word_sched;

    logic       clk;
    logic       rst;
    logic       req0;
    logic [7:0] data0;
    logic       ack0;
    logic       req1;
    logic [7:0] data1;
    logic       ack1;
    logic       busy;
    logic       done;
    logic       div3;
    logic       gnt_id;
    logic [1:0] rem;

    mod3_word_sched dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .data0  (data0),
        .ack0   (ack0),
        .req1   (req1),
        .data1  (data1),
        .ack1   (ack1),
        .busy   (busy),
        .done   (done),
        .div3   (div3),
        .gnt_id (gnt_id)
`ifdef MOD3_REM_EN
        ,
        .rem    (rem)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // model: m_phase counts cycles since acceptance (0 = idle), result = word % 3
    int   m_phase = 0;
    bit   m_ptr   = 1'b1;
    bit   m_id    = 1'b0;
    int   m_word  = 0;
    bit   m_div3  = 1'b0;
    bit   m_gnt   = 1'b0;
    int   m_rem   = 0;

    int   cyc       = 0;
    int   obs_done  = 0;
    int   last_ack0 = 0;
    int   last_ack1 = 0;
    int   last_done = 0;
    bit   auto_req  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic cycle();
        bit dropped0;
        bit dropped1;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            m_phase = 0;
            m_ptr   = 1'b1;
            m_div3  = 1'b0;
            m_gnt   = 1'b0;
            m_rem   = 0;
        end else if (m_phase == 0) begin
            if (req0 || req1) begin
                m_id    = (req0 && req1) ? !m_ptr : req1;
                m_ptr   = m_id;
                m_word  = m_id ? int'(data1) : int'(data0);
                m_phase = 1;
            end
        end else if (m_phase == 9) begin
            m_phase = 0;
        end else begin
            m_phase++;
            if (m_phase == 9) begin
                m_div3 = (m_word % 3) == 0;
                m_gnt  = m_id;
                m_rem  = m_word % 3;
            end
        end
        check("ack0",   ack0,   m_phase == 1 && !m_id);
        check("ack1",   ack1,   m_phase == 1 && m_id);
        check("busy",   busy,   m_phase != 0);
        check("done",   done,   m_phase == 9);
        check("div3",   div3,   m_div3);
        check("gnt_id", gnt_id, m_gnt);
`ifdef MOD3_REM_EN
        check("rem",    rem,    m_rem);
`endif
        if (ack0) last_ack0 = cyc;
        if (ack1) last_ack1 = cyc;
        if (done) begin
            last_done = cyc;
            obs_done++;
        end
        dropped0 = 1'b0;
        dropped1 = 1'b0;
        if (m_phase == 1 && !rst) begin
            if (m_id) begin req1 = 1'b0; dropped1 = 1'b1; end
            else      begin req0 = 1'b0; dropped0 = 1'b1; end
        end
        if (auto_req) begin
            rst = ($urandom_range(199) == 0);
            if (!req0 && !dropped0 && $urandom_range(3) == 0) begin
                req0  = 1'b1;
                data0 = 8'($urandom);
            end
            if (!req1 && !dropped1 && $urandom_range(3) == 0) begin
                req1  = 1'b1;
                data1 = 8'($urandom);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 24; i++) begin
            cycle();
            if (done) break;
        end
        check({tag, "_timeout"}, done, 1'b1);
    endtask

    task automatic wait_ack0(input string tag);
        for (int i = 0; i < 24; i++) begin
            cycle();
            if (ack0) break;
        end
        check({tag, "_timeout"}, ack0, 1'b1);
    endtask

    int nd;

    initial begin
        rst   = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        data0 = 8'd0;
        data1 = 8'd0;
        run(2);
        rst = 1'b0;
        check("rst_ack0", ack0, 1'b0);
        check("rst_ack1", ack1, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_div3", div3, 1'b0);
        check("rst_gnt",  gnt_id, 1'b0);

        // word 9 from requester 0
        req0 = 1'b1; data0 = 8'd9;
        wait_done("w9");
        check("w9_div3", div3, 1'b1);
        check("w9_gnt",  gnt_id, 1'b0);
        check("w9_lat",  last_done - last_ack0, 8);
`ifdef MOD3_REM_EN
        check("w9_rem",  rem, 2'd0);
`endif
        run(1);

        // word 10 from requester 1
        req1 = 1'b1; data1 = 8'd10;
        wait_done("w10");
        check("w10_div3", div3, 1'b0);
        check("w10_gnt",  gnt_id, 1'b1);
        check("w10_lat",  last_done - last_ack1, 8);
`ifdef MOD3_REM_EN
        check("w10_rem",  rem, 2'd1);
`endif
        run(1);

        // extremes 0 and 1
        req0 = 1'b1; data0 = 8'd0;
        wait_done("w0");
        check("w0_div3", div3, 1'b1);
`ifdef MOD3_REM_EN
        check("w0_rem",  rem, 2'd0);
`endif
        run(1);
        req0 = 1'b1; data0 = 8'd1;
        wait_done("w1");
        check("w1_div3", div3, 1'b0);
`ifdef MOD3_REM_EN
        check("w1_rem",  rem, 2'd1);
`endif
        run(1);

        // contention held from reset: req0 first, req1 ten cycles later
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; data0 = 8'd255; data1 = 8'd128;
        run(2);
        rst = 1'b0;
        wait_done("rr1");
        check("rr1_gnt",  gnt_id, 1'b0);
        check("rr1_div3", div3, 1'b1);
        wait_done("rr2");
        check("rr2_gnt",  gnt_id, 1'b1);
        check("rr2_div3", div3, 1'b0);
        check("rr_gap",   last_ack1 - last_ack0, 10);
`ifdef MOD3_REM_EN
        check("rr2_rem",  rem, 2'd2);
`endif
        run(1);

        // reset in the 4th shift cycle abandons the word
        req0 = 1'b1; data0 = 8'd200;
        wait_ack0("abort");
        run(3);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_div3", div3, 1'b0);
        check("abort_gnt",  gnt_id, 1'b0);
        nd = obs_done;
        run(12);
        check("abort_nodone", obs_done - nd, 0);
        req0 = 1'b1; data0 = 8'd33;
        wait_done("after_abort");
        check("after_abort_div3", div3, 1'b1);
        check("after_abort_gnt",  gnt_id, 1'b0);
        run(1);

        // randomized traffic with occasional resets
        auto_req = 1'b1;
        run(4000);
        auto_req = 1'b0;
        rst = 1'b0;
        run(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
